// File: rtl/ls_apb_pkg.sv
// Shared types for the LightSeparator APB master: FSM state encoding and the
// queued command record.
package ls_apb_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 16;
   localparam int FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } apb_cmd_t;

   // Reads put zero on PWDATA so stale write data never leaks onto the bus.
   function automatic logic [DATA_WIDTH-1:0] bus_wdata(input apb_cmd_t cmd);
      return cmd.write ? cmd.wdata : {DATA_WIDTH{1'b0}};
   endfunction

endpackage

// File: rtl/ls_cmd_fifo.sv
// Synchronous command FIFO for the APB master; power-of-2 depth, pointers wrap
// naturally, count is one bit wider than the pointers.
module ls_cmd_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  ls_apb_pkg::apb_cmd_t      din,
   output ls_apb_pkg::apb_cmd_t      head,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);
   import ls_apb_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   apb_cmd_t      r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign w_push = push && (r_count != DEPTH_C);
   assign w_pop  = pop && (r_count != (PW+1)'(0));

   // Storage, pointers and occupancy; reset flushes everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= PW'(0);
         r_rd_ptr <= PW'(0);
         r_count  <= (PW+1)'(0);
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign full  = (r_count == DEPTH_C);
   assign empty = (r_count == (PW+1)'(0));
   assign count = r_count;

endmodule

// File: rtl/ls_apb_master.sv
// APB master for the LightSeparator bus: queues commands and issues them as
// back-to-back SETUP/ACCESS pairs, returning read data on a one-cycle strobe.
module ls_apb_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  busy
);
   import ls_apb_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   apb_state_e            r_state;
   apb_state_e            w_state_nxt;
   apb_cmd_t              w_din;
   apb_cmd_t              w_head;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [CW-1:0]         w_count;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  w_read_done;

   // Ready is forced low while reset is asserted, not only after it is sampled.
   assign cmd_ready = rst && !w_full;
   assign w_push    = cmd_valid && cmd_ready;

   always_comb begin
      w_din.write = cmd_write;
      w_din.addr  = cmd_addr;
      w_din.wdata = cmd_wdata;
   end

   ls_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_din),
      .head  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // Next-state and pop decision; a new command is taken from IDLE or ACCESS.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_state_nxt = SETUP;
               w_pop       = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SETUP: w_state_nxt = ACCESS;
         ACCESS: begin
            if (!w_empty) begin
               w_state_nxt = SETUP;
               w_pop       = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign w_read_done = (r_state == ACCESS) && !r_pwrite;

   // Registered bus and response outputs; address/data only move on a pop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= {ADDR_WIDTH{1'b0}};
         r_pwdata    <= {DATA_WIDTH{1'b0}};
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= {DATA_WIDTH{1'b0}};
      end else begin
         r_psel      <= (w_state_nxt != IDLE);
         r_penable   <= (w_state_nxt == ACCESS);
         r_rsp_valid <= w_read_done;
         if (w_pop) begin
            r_pwrite <= w_head.write;
            r_paddr  <= w_head.addr;
            r_pwdata <= bus_wdata(w_head);
         end
         if (w_read_done) begin
            r_rsp_rdata <= PRDATA;
         end
      end
   end

   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;
   assign PWRITE    = r_pwrite;
   assign PADDR     = r_paddr;
   assign PWDATA    = r_pwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign busy      = (w_count != CW'(0)) || (r_state != IDLE);

endmodule

// File: tb/tb_ls_apb_master.sv
// Randomised bench for ls_apb_master against a queue-based transaction model
// of the command buffer and the APB phase sequence.
module tb_ls_apb_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [15:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        busy;

   always #5 clk = ~clk;

   ls_apb_master dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .busy(busy)
   );

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [31:0] d;
   } cmd_t;

   // Reference model: pending commands, bus phase (0 idle, 1 setup, 2 access)
   cmd_t        m_q[$];
   int          m_phase = 0;
   logic        m_write = 1'b0;
   logic [15:0] m_addr = 16'h0;
   logic [31:0] m_wdata = 32'h0;
   logic        m_rsp_valid = 1'b0;
   logic [31:0] m_rsp_rdata = 32'h0;

   int n_checks = 0;
   int n_fail = 0;
   int n_rsp_seen = 0;
   int n_psel_seen = 0;
   bit hold_prdata = 1'b0;
   bit saw_not_ready = 1'b0;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [15:0] a, input logic [31:0] d);
      cmd_valid = v;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
   endtask

   // One clock: advance the model on the edge, then compare on the falling edge.
   task automatic step(output bit accepted);
      cmd_t c;
      cmd_t nx;
      bit   push;
      if (!hold_prdata) PRDATA = $urandom();
      push = cmd_valid && rst && (m_q.size() < 4);
      c.w = cmd_write;
      c.a = cmd_addr;
      c.d = cmd_wdata;
      accepted = push;
      @(posedge clk);
      if (!rst) begin
         m_q.delete();
         m_phase = 0;
         m_write = 1'b0;
         m_addr = 16'h0;
         m_wdata = 32'h0;
         m_rsp_valid = 1'b0;
         m_rsp_rdata = 32'h0;
      end else begin
         m_rsp_valid = (m_phase == 2) && !m_write;
         if (m_rsp_valid) m_rsp_rdata = PRDATA;
         if (m_phase != 1 && m_q.size() > 0) begin
            nx = m_q.pop_front();
            m_write = nx.w;
            m_addr = nx.a;
            m_wdata = nx.w ? nx.d : 32'h0;
            m_phase = 1;
         end else if (m_phase == 1) begin
            m_phase = 2;
         end else begin
            m_phase = 0;
         end
         if (push) m_q.push_back(c);
      end
      @(negedge clk);
      chk_eq("psel", PSEL, m_phase != 0);
      chk_eq("penable", PENABLE, m_phase == 2);
      chk_eq("pwrite", PWRITE, m_write);
      chk_eq("paddr", PADDR, m_addr);
      chk_eq("pwdata", PWDATA, m_wdata);
      chk_eq("rsp_valid", rsp_valid, m_rsp_valid);
      chk_eq("rsp_rdata", rsp_rdata, m_rsp_rdata);
      chk_eq("busy", busy, (m_q.size() != 0) || (m_phase != 0));
      chk_eq("cmd_ready", cmd_ready, rst && (m_q.size() < 4));
      if (rsp_valid) n_rsp_seen++;
      if (PSEL) n_psel_seen++;
      if (rst && !cmd_ready) saw_not_ready = 1'b1;
   endtask

   task automatic idle(input int n);
      bit acc;
      drive(1'b0, 1'b0, 16'h0, 32'h0);
      for (int i = 0; i < n; i++) step(acc);
   endtask

   initial begin
      bit acc;
      int r0;
      int p0;
      rst = 1'b0;
      PRDATA = 32'h0;
      drive(1'b0, 1'b0, 16'h0, 32'h0);
      idle(3);
      rst = 1'b1;

      // Reset cut during ACCESS of a queued write
      drive(1'b1, 1'b1, 16'h0100, 32'h1111_2222);
      step(acc);
      idle(2);
      chk_eq("pre_rst_access", PENABLE, 1'b1);
      rst = 1'b0;
      idle(1);
      chk_eq("rst_psel", PSEL, 1'b0);
      chk_eq("rst_busy", busy, 1'b0);
      rst = 1'b1;
      idle(1);

      // Single write
      drive(1'b1, 1'b1, 16'h0010, 32'hA5A5_0001);
      step(acc);
      idle(4);

      // Single read with slave returning 0xFF
      hold_prdata = 1'b1;
      PRDATA = 32'h0000_00FF;
      drive(1'b1, 1'b0, 16'h0004, 32'hDEAD_BEEF);
      step(acc);
      idle(4);
      chk_eq("read_ff", rsp_rdata, 32'h0000_00FF);
      hold_prdata = 1'b0;

      // Burst W,R,W,R: PSEL high 8 cycles, two responses
      r0 = n_rsp_seen;
      p0 = n_psel_seen;
      drive(1'b1, 1'b1, 16'h0020, 32'h0000_1000); step(acc);
      drive(1'b1, 1'b0, 16'h0024, 32'h0000_2000); step(acc);
      drive(1'b1, 1'b1, 16'h0028, 32'h0000_3000); step(acc);
      drive(1'b1, 1'b0, 16'h002C, 32'h0000_4000); step(acc);
      idle(10);
      chk_eq("burst_rsp", n_rsp_seen - r0, 2);
      chk_eq("burst_psel", n_psel_seen - p0, 8);

      // Continuous pushes until the FIFO fills and backpressures
      saw_not_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         int tries = 0;
         drive(1'b1, i[0], 16'h0100 + 16'(i * 4), 32'hC000_0000 + 32'(i));
         acc = 1'b0;
         while (!acc && tries < 20) begin
            step(acc);
            tries++;
         end
         chk_eq("push_timeout", acc, 1'b1);
      end
      idle(20);
      chk_eq("full_backpressure", saw_not_ready, 1'b1);

      // Push landing on the edge the last ACCESS ends
      drive(1'b1, 1'b1, 16'h0200, 32'h0000_0A0A); step(acc);
      idle(2);
      drive(1'b1, 1'b0, 16'h0204, 32'h0); step(acc);
      chk_eq("late_busy", busy, 1'b1);
      idle(5);

      // Random traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 99) != 0);
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               16'($urandom()), $urandom());
         step(acc);
      end
      rst = 1'b1;
      idle(12);
      chk_eq("drained_busy", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
